ps2_keyboard_rx: RTL

Receives device-to-host PS/2 keyboard frames on the board's `ps2_clk`/`ps2_data` lines and decodes scan-code set 2 into eight held-key flags. These flags drive the paddle controls (`p1_up` … `p2_right`) of the Pong display controller in place of push-buttons. The block only listens: it never drives the PS/2 lines. It also exposes raw scan codes for debug on the seven-segment decoder.

---
 rtl/ps2_keyboard_rx_pkg.sv | 63 ++++++
 rtl/ps2_keyboard_rx_if.sv | 32 +++
 rtl/ps2_keyboard_rx_frame_rx.sv | 146 ++++++++++++++
 rtl/ps2_keyboard_rx.sv | 83 ++++++++
 4 files changed

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM states,
// scan-code set 2 values and the held-key flag layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int NUM_KEYS = 8;
    localparam logic [2:0] KEY_P1_UP    = 3'd0;
    localparam logic [2:0] KEY_P1_DOWN  = 3'd1;
    localparam logic [2:0] KEY_P1_LEFT  = 3'd2;
    localparam logic [2:0] KEY_P1_RIGHT = 3'd3;
    localparam logic [2:0] KEY_P2_UP    = 3'd4;
    localparam logic [2:0] KEY_P2_DOWN  = 3'd5;
    localparam logic [2:0] KEY_P2_LEFT  = 3'd6;
    localparam logic [2:0] KEY_P2_RIGHT = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    // Keypad codes share values with the arrows, so the E0 prefix must match too.
    function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] sc);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = KEY_P1_UP;
        if (!ext) begin
            case (sc)
                SC_W:    r.idx = KEY_P1_UP;
                SC_S:    r.idx = KEY_P1_DOWN;
                SC_A:    r.idx = KEY_P1_LEFT;
                SC_D:    r.idx = KEY_P1_RIGHT;
                default: r.hit = 1'b0;
            endcase
        end else begin
            case (sc)
                SC_UP:    r.idx = KEY_P2_UP;
                SC_DOWN:  r.idx = KEY_P2_DOWN;
                SC_LEFT:  r.idx = KEY_P2_LEFT;
                SC_RIGHT: r.idx = KEY_P2_RIGHT;
                default:  r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Bundle of PS/2 line inputs and decoded keyboard outputs; the receiver is the
// slave, the board/test side is the master.
interface ps2_kbd_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid;
    logic       parity_err;
    logic       frame_err;
    logic       p1_up;
    logic       p1_down;
    logic       p1_left;
    logic       p1_right;
    logic       p2_up;
    logic       p2_down;
    logic       p2_left;
    logic       p2_right;

    modport master (
        output ps2_clk, ps2_data,
        input  code, code_valid, parity_err, frame_err,
        input  p1_up, p1_down, p1_left, p1_right,
        input  p2_up, p2_down, p2_left, p2_right
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output code, code_valid, parity_err, frame_err,
        output p1_up, p1_down, p1_left, p1_right,
        output p2_up, p2_down, p2_left, p2_right
    );
endinterface

// File: rtl/ps2_keyboard_rx_frame_rx.sv
// PS/2 device-to-host frame receiver: line synchronizers, clock glitch filter,
// 11-bit frame FSM with odd-parity/stop checking and an inter-bit timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);

    localparam int FCW     = $clog2(FILTER_LEN + 1);
    localparam int TCW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TCW     = (TCW_RAW < 18) ? 18 : TCW_RAW;
    localparam logic [FCW-1:0] FCNT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYCLES - 1);

    logic [1:0]     clk_s_q, dat_s_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    frame_state_e   state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic [7:0]     code_q, code_d;
    logic           cv_q, pe_q, fe_q;

    logic fall_w, timeout_w, dat_w;
    logic good_w, perr_w, ferr_w;

    assign dat_w = dat_s_q[1];

    // Filtered level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s_q[1] != filt_q) begin
            if (fcnt_q == FCNT_MAX) begin
                filt_d = clk_s_q[1];
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall_w    = filt_q & ~filt_d;
    assign timeout_w = (state_q != ST_IDLE) && !fall_w && (tmo_q == TMO_MAX);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_w) begin
            state_d = ST_IDLE;
        end else if (fall_w) begin
            case (state_q)
                ST_IDLE:   if (!dat_w) state_d = ST_DATA;
                ST_DATA:   if (bitcnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // A bad stop bit outranks a parity failure.
    always_comb begin
        good_w = 1'b0;
        perr_w = 1'b0;
        ferr_w = 1'b0;
        if (timeout_w) begin
            ferr_w = 1'b1;
        end else if (fall_w && state_q == ST_STOP) begin
            if (!dat_w)                   ferr_w = 1'b1;
            else if (!(^{shreg_q, par_q})) perr_w = 1'b1;
            else                          good_w = 1'b1;
        end
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        tmo_d    = (state_q == ST_IDLE || fall_w) ? '0 : tmo_q + 1'b1;
        code_d   = good_w ? shreg_q : code_q;
        if (fall_w && !timeout_w) begin
            case (state_q)
                ST_IDLE:   bitcnt_d = '0;
                ST_DATA: begin
                    shreg_d  = {dat_w, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                ST_PARITY: par_d = dat_w;
                default:   ;
            endcase
        end
    end

    // Sync flops and filter idle high so reset release never fakes a fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_s_q  <= 2'b11;
            dat_s_q  <= 2'b11;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            code_q   <= '0;
            cv_q     <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            clk_s_q  <= {clk_s_q[0], ps2_clk_i};
            dat_s_q  <= {dat_s_q[0], ps2_data_i};
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            code_q   <= code_d;
            cv_q     <= good_w;
            pe_q     <= perr_w;
            fe_q     <= ferr_w;
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = cv_q;
    assign parity_err_o = pe_q;
    assign frame_err_o  = fe_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame reception plus scan-code set 2 decoding of
// E0/F0 prefixes into eight held-key flags for the paddle controls.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic     clk,
    input  logic     reset,
    ps2_kbd_if.slave bus
);

    logic [7:0]          code_w;
    logic                cv_w, pe_w, fe_w;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    key_hit_t            hit_w;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .code_o       (code_w),
        .code_valid_o (cv_w),
        .parity_err_o (pe_w),
        .frame_err_o  (fe_w)
    );

    assign hit_w = key_lookup(ext_q, code_w);

    // Errors drop any pending prefix but keep held keys.
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        keys_d = keys_q;
        if (pe_w || fe_w) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (cv_w) begin
            if (code_w == SC_EXT) begin
                ext_d = 1'b1;
            end else if (code_w == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                if (hit_w.hit) keys_d[hit_w.idx] = ~brk_q;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            keys_q <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            keys_q <= keys_d;
        end
    end

    assign bus.code       = code_w;
    assign bus.code_valid = cv_w;
    assign bus.parity_err = pe_w;
    assign bus.frame_err  = fe_w;
    assign bus.p1_up      = keys_q[KEY_P1_UP];
    assign bus.p1_down    = keys_q[KEY_P1_DOWN];
    assign bus.p1_left    = keys_q[KEY_P1_LEFT];
    assign bus.p1_right   = keys_q[KEY_P1_RIGHT];
    assign bus.p2_up      = keys_q[KEY_P2_UP];
    assign bus.p2_down    = keys_q[KEY_P2_DOWN];
    assign bus.p2_left    = keys_q[KEY_P2_LEFT];
    assign bus.p2_right   = keys_q[KEY_P2_RIGHT];

endmodule
